// File: rtl/ecc_op_monitor.sv
// Passive APB control-path monitor: checks completion latency, flags protocol violations, keeps sticky flags and saturating counters.
// All outputs are registered and update one edge after the observed event. The block never drives the bus, so there is no backpressure.
module ecc_op_monitor #(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int DATA_WIDTH      = 32,
  parameter int MIN_LAT         = 1,
  parameter int MAX_LAT         = 3,
  parameter int CNT_WIDTH       = 8,
  localparam int LAT_W          = $clog2(MAX_LAT + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic                       operation_done,
  input  logic [1:0]                 num_of_errors,
  input  logic                       clear,
  output logic [4:0]                 err_pulse,
  output logic [4:0]                 err_sticky,
  output logic [5*CNT_WIDTH-1:0]     err_cnt,
  output logic [CNT_WIDTH-1:0]       op_cnt,
  output logic [LAT_W-1:0]           lat_last,
  output logic                       busy
);

  if (MIN_LAT < 1 || MAX_LAT < MIN_LAT || DATA_WIDTH < 1) begin : g_bad_params
    $error("ecc_op_monitor: illegal parameter set");
  end

  typedef enum logic {IDLE, PEND} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t                           state_q, state_d;
  logic [LAT_W-1:0]                 lat_q, lat_d, lat_inc;
  logic [4:0]                       pulse_q, pulse_d;
  logic [4:0]                       sticky_q, sticky_d;
  logic [4:0][CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]             op_cnt_q, op_cnt_d;
  logic [LAT_W-1:0]                 lat_last_q, lat_last_d;
  logic                             valid_done;
  logic                             cw;

  assign cw = PSEL & PENABLE & PWRITE & (PADDR == '0);

  // Bit map: 0 TIMEOUT, 1 EARLY, 2 SPURIOUS, 3 OVERLAP, 4 BADNUM.
  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    lat_inc    = lat_q + LAT_W'(1);
    pulse_d    = '0;
    valid_done = 1'b0;
    pulse_d[4] = operation_done & (num_of_errors == 2'b11);
    case (state_q)
      IDLE: begin
        pulse_d[2] = operation_done;
        if (cw) begin
          state_d = PEND;
          lat_d   = '0;
        end
      end
      PEND: begin
        if (operation_done) begin
          // Done is judged against the old op; a same-edge CW simply starts the next one.
          if (lat_inc < LAT_W'(MIN_LAT)) pulse_d[1] = 1'b1;
          else                           valid_done = 1'b1;
          state_d = cw ? PEND : IDLE;
          lat_d   = '0;
        end else if (cw) begin
          pulse_d[3] = 1'b1;
          lat_d      = '0;
        end else if (lat_inc == LAT_W'(MAX_LAT)) begin
          pulse_d[0] = 1'b1;
          state_d    = IDLE;
          lat_d      = '0;
        end else begin
          lat_d = lat_inc;
        end
      end
      default: begin
        state_d = IDLE;
        lat_d   = '0;
      end
    endcase
  end

  // Clear wipes history but keeps whatever happens on the clear edge itself.
  always_comb begin
    sticky_d   = clear ? pulse_d : (sticky_q | pulse_d);
    op_cnt_d   = clear ? '0 : op_cnt_q;
    lat_last_d = clear ? '0 : lat_last_q;
    if (valid_done) begin
      lat_last_d = lat_inc;
      if (op_cnt_d != CNT_MAX) op_cnt_d = op_cnt_d + CNT_WIDTH'(1);
    end
    for (int i = 0; i < 5; i++) begin
      cnt_d[i] = clear ? '0 : cnt_q[i];
      if (pulse_d[i] && cnt_d[i] != CNT_MAX) cnt_d[i] = cnt_d[i] + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      lat_q      <= '0;
      pulse_q    <= '0;
      sticky_q   <= '0;
      cnt_q      <= '0;
      op_cnt_q   <= '0;
      lat_last_q <= '0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      pulse_q    <= pulse_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
      op_cnt_q   <= op_cnt_d;
      lat_last_q <= lat_last_d;
    end
  end

  assign err_pulse  = pulse_q;
  assign err_sticky = sticky_q;
  assign err_cnt    = cnt_q;
  assign op_cnt     = op_cnt_q;
  assign lat_last   = lat_last_q;
  assign busy       = (state_q == PEND);

endmodule
